// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared widths, queue entry type and scoreboard helper for the write-back queue
package wb_queue_pkg;
  localparam int REG_ADDRW = 5;
  localparam int CPU_WIDTH = 32;
  localparam int REG_COUNT = 1 << REG_ADDRW;
  localparam int WBQ_DEPTH = 4;
  typedef logic [REG_ADDRW-1:0] reg_addr_t;
  typedef logic [CPU_WIDTH-1:0] cpu_data_t;
  typedef struct packed {
    reg_addr_t rd;
    cpu_data_t data;
  } wbq_entry_t;
  function automatic logic [REG_COUNT-1:0] reg_onehot(input reg_addr_t r);
    return REG_COUNT'(1) << r;
  endfunction
endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: producer, issue, scoreboard and regfile-write signals of the write-back queue
// Forwarding ports exist only when WBQ_FWD_EN is defined.
interface wb_queue_if;
  import wb_queue_pkg::*;
  logic lsu_valid, lsu_ready;
  reg_addr_t lsu_rd;
  cpu_data_t lsu_data;
  logic exu_valid, exu_ready;
  reg_addr_t exu_rd;
  cpu_data_t exu_data;
  logic iss_valid;
  reg_addr_t iss_rd;
  logic [REG_COUNT-1:0] busy;
  logic wen;
  reg_addr_t waddr;
  cpu_data_t wdata;
  logic empty;
`ifdef WBQ_FWD_EN
  reg_addr_t fwd_raddr1, fwd_raddr2;
  logic fwd_hit1, fwd_hit2;
  cpu_data_t fwd_data1, fwd_data2;
`endif
  modport slave (
    input lsu_valid, lsu_rd, lsu_data, exu_valid, exu_rd, exu_data, iss_valid, iss_rd,
    output lsu_ready, exu_ready, busy, wen, waddr, wdata, empty
`ifdef WBQ_FWD_EN
    , input fwd_raddr1, fwd_raddr2, output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
  );
  modport master (
    output lsu_valid, lsu_rd, lsu_data, exu_valid, exu_rd, exu_data, iss_valid, iss_rd,
    input lsu_ready, exu_ready, busy, wen, waddr, wdata, empty
`ifdef WBQ_FWD_EN
    , output fwd_raddr1, fwd_raddr2, input fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
  );
endinterface

// File: rtl/wb_queue_fifo.sv
// wb_queue_fifo: DEPTH-entry FIFO with two ordered pushes (a before b) and one pop per cycle
module wb_queue_fifo import wb_queue_pkg::*; #(
  parameter int DEPTH = WBQ_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_a,
  input  logic          push_b,
  input  logic          pop,
  input  wbq_entry_t    entry_a,
  input  wbq_entry_t    entry_b,
  output wbq_entry_t    head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] space,
  output logic [PW-1:0] head_ptr,
  output wbq_entry_t    mem [DEPTH]
);
  logic [PW-1:0] tail;
  assign head = mem[head_ptr];
  // a non-empty queue always pops this cycle, so its head slot counts as free
  assign space = CW'(DEPTH) - count + CW'(count != '0);
  always_ff @(posedge clk) begin
    if (push_a) mem[tail] <= entry_a;
    if (push_b) mem[tail + PW'(1)] <= entry_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tail <= '0;
      head_ptr <= '0;
      count <= '0;
    end else begin
      tail <= tail + PW'(push_a) + PW'(push_b);
      head_ptr <= head_ptr + PW'(pop);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
endmodule

// File: rtl/wb_queue.sv
// wb_queue: write-back queue feeding the single regfile write port, with per-register pending scoreboard
// Define WBQ_FWD_EN to add combinational forwarding of queued results.
module wb_queue import wb_queue_pkg::*; #(
  parameter int DEPTH = WBQ_DEPTH
) (
  input logic i_clk,
  input logic i_rst,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wbq_entry_t head, lsu_entry, exu_entry;
  wbq_entry_t mem [DEPTH];
  logic [CW-1:0] count, space;
  logic [PW-1:0] head_ptr;
  logic lsu_rdy, exu_rdy, lsu_keep, exu_keep, pop;
  logic [REG_COUNT-1:0] busy;
  always_comb begin
    lsu_rdy = ~i_rst & (space >= CW'(1));
    exu_rdy = ~i_rst & ((space >= CW'(2)) | ((space == CW'(1)) & ~bus.lsu_valid));
    lsu_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};
    exu_entry = '{rd: bus.exu_rd, data: bus.exu_data};
    // writes to x0 complete the handshake but never occupy a slot
    lsu_keep = bus.lsu_valid & lsu_rdy & (bus.lsu_rd != '0);
    exu_keep = bus.exu_valid & exu_rdy & (bus.exu_rd != '0);
    pop = ~i_rst & (count != '0);
    bus.lsu_ready = lsu_rdy;
    bus.exu_ready = exu_rdy;
    bus.wen = pop;
    bus.waddr = pop ? head.rd : '0;
    bus.wdata = pop ? head.data : '0;
    bus.busy = busy;
    bus.empty = (count == '0) & (busy == '0);
  end
  wb_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push_a(lsu_keep | exu_keep),
    .push_b(lsu_keep & exu_keep),
    .pop(pop),
    .entry_a(lsu_keep ? lsu_entry : exu_entry),
    .entry_b(exu_entry),
    .head(head),
    .count(count),
    .space(space),
    .head_ptr(head_ptr),
    .mem(mem)
  );
  // issue-side set is OR'd in after the retire clear so it wins on the same register
  always_ff @(posedge i_clk) begin
    if (i_rst) busy <= '0;
    else busy <= (busy & ~(pop ? reg_onehot(head.rd) : '0))
               | ((bus.iss_valid && bus.iss_rd != '0) ? reg_onehot(bus.iss_rd) : '0);
  end
`ifdef WBQ_FWD_EN
  always_comb begin
    bus.fwd_hit1 = 1'b0;
    bus.fwd_hit2 = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && mem[head_ptr + PW'(i)].rd == bus.fwd_raddr1 && bus.fwd_raddr1 != '0) begin
        bus.fwd_hit1 = 1'b1;
        bus.fwd_data1 = mem[head_ptr + PW'(i)].data;
      end
      if (CW'(i) < count && mem[head_ptr + PW'(i)].rd == bus.fwd_raddr2 && bus.fwd_raddr2 != '0) begin
        bus.fwd_hit2 = 1'b1;
        bus.fwd_data2 = mem[head_ptr + PW'(i)].data;
      end
    end
  end
`else
  logic unused_fwd;
  always_comb begin
    unused_fwd = ^head_ptr;
    for (int i = 0; i < DEPTH; i++) unused_fwd = unused_fwd ^ (^mem[i]);
  end
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus for wb_queue checked every cycle against a queue-based reference model
module tb_wb_queue;
  import wb_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  wbq_entry_t mq[$];
  logic [REG_COUNT-1:0] mbusy = '0;
  wbq_entry_t wlog[$];
  wb_queue_if bus();
  wb_queue #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic int model_space();
    int sz = mq.size();
    return DEPTH - sz + ((sz != 0) ? 1 : 0);
  endfunction

  function automatic logic exp_lsu_ready();
    return model_space() >= 1;
  endfunction

  function automatic logic exp_exu_ready();
    return model_space() >= 2 || (model_space() == 1 && !bus.lsu_valid);
  endfunction

  initial forever begin
    logic lr, er;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mbusy = '0;
    end else begin
      lr = exp_lsu_ready();
      er = exp_exu_ready();
      if (mq.size() != 0) begin
        mbusy[mq[0].rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (bus.lsu_valid && lr && bus.lsu_rd != 0) mq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
      if (bus.exu_valid && er && bus.exu_rd != 0) mq.push_back('{rd: bus.exu_rd, data: bus.exu_data});
      if (bus.iss_valid && bus.iss_rd != 0) mbusy[bus.iss_rd] = 1'b1;
      chk("model_occupancy", 64'(mq.size() <= DEPTH), 64'd1);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      chk("rst_exu_ready", 64'(bus.exu_ready), 64'd0);
      chk("rst_wen", 64'(bus.wen), 64'd0);
    end else begin
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(exp_lsu_ready()));
      chk("exu_ready", 64'(bus.exu_ready), 64'(exp_exu_ready()));
      chk("wen", 64'(bus.wen), 64'(mq.size() != 0));
      chk("waddr", 64'(bus.waddr), (mq.size() != 0) ? 64'(mq[0].rd) : 64'd0);
      chk("wdata", 64'(bus.wdata), (mq.size() != 0) ? 64'(mq[0].data) : 64'd0);
      chk("busy", 64'(bus.busy), 64'(mbusy));
      chk("empty", 64'(bus.empty), 64'(mq.size() == 0 && mbusy == 0));
      if (bus.wen) wlog.push_back('{rd: bus.waddr, data: bus.wdata});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.lsu_valid = 1'b0;
    bus.lsu_rd = '0;
    bus.lsu_data = '0;
    bus.exu_valid = 1'b0;
    bus.exu_rd = '0;
    bus.exu_data = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd = '0;
  endtask

  task automatic push(input logic lv, input int lrd, input int ld, input logic ev, input int erd, input int ed);
    bus.lsu_valid = lv;
    bus.lsu_rd = reg_addr_t'(lrd);
    bus.lsu_data = cpu_data_t'(ld);
    bus.exu_valid = ev;
    bus.exu_rd = reg_addr_t'(erd);
    bus.exu_data = cpu_data_t'(ed);
  endtask

  initial begin
    int exp_rd[7];
    int exp_dat[7];
    exp_rd = '{8, 9, 10, 11, 12, 13, 14};
    exp_dat = '{100, 200, 101, 201, 102, 202, 103};
    idle();
`ifdef WBQ_FWD_EN
    bus.fwd_raddr1 = '0;
    bus.fwd_raddr2 = '0;
`endif
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("t1_wen", 64'(bus.wen), 64'd0);
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_empty", 64'(bus.empty), 64'd1);
    chk("t1_readys", 64'({bus.lsu_ready, bus.exu_ready}), 64'd3);
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd5;
    step();
    idle();
    push(0, 0, 0, 1, 5, 'h1234);
    #1;
    chk("t2_busy_set", 64'(bus.busy[5]), 64'd1);
    chk("t2_not_empty", 64'(bus.empty), 64'd0);
    step();
    idle();
    #1;
    chk("t2_wen", 64'(bus.wen), 64'd1);
    chk("t2_waddr", 64'(bus.waddr), 64'd5);
    chk("t2_wdata", 64'(bus.wdata), 64'h1234);
    chk("t2_busy_hold", 64'(bus.busy[5]), 64'd1);
    step();
    chk("t2_busy_clr", 64'(bus.busy[5]), 64'd0);
    chk("t2_idle_wen", 64'(bus.wen), 64'd0);
    push(1, 3, 'hA, 1, 4, 'hB);
    step();
    idle();
    #1;
    chk("t3_first", 64'({bus.wen, bus.waddr, bus.wdata}), {27'd0, 1'b1, 5'd3, 32'hA});
    step();
    chk("t3_second", 64'({bus.wen, bus.waddr, bus.wdata}), {27'd0, 1'b1, 5'd4, 32'hB});
    step();
    chk("t3_drained", 64'(bus.wen), 64'd0);
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      push(1, 8 + 2 * k, 100 + k, 1, 9 + 2 * k, 200 + k);
      #1;
      chk("t4_lsu_ready", 64'(bus.lsu_ready), 64'd1);
      chk("t4_exu_ready", 64'(bus.exu_ready), (k == 3) ? 64'd0 : 64'd1);
      step();
    end
    idle();
    repeat (8) step();
    chk("t4_write_count", 64'(wlog.size()), 64'd7);
    for (int i = 0; i < 7 && i < wlog.size(); i++) begin
      chk("t4_order_rd", 64'(wlog[i].rd), 64'(exp_rd[i]));
      chk("t4_order_data", 64'(wlog[i].data), 64'(exp_dat[i]));
    end
    push(0, 0, 0, 1, 0, 'hFFFF);
    #1;
    chk("t5_exu_ready", 64'(bus.exu_ready), 64'd1);
    step();
    idle();
    #1;
    chk("t5_wen", 64'(bus.wen), 64'd0);
    chk("t5_empty", 64'(bus.empty), 64'd1);
    push(1, 20, 'h20, 1, 21, 'h21);
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd6;
    step();
    idle();
    push(1, 22, 'h22, 1, 23, 'h23);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("t6_held_wen", 64'(bus.wen), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_wen", 64'(bus.wen), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_empty", 64'(bus.empty), 64'd1);
    step();
    chk("t6_still_idle", 64'(bus.wen), 64'd0);
`ifdef WBQ_FWD_EN
    push(1, 7, 1, 1, 7, 2);
    step();
    idle();
    bus.fwd_raddr1 = 5'd7;
    bus.fwd_raddr2 = 5'd0;
    #1;
    chk("fwd_hit1", 64'(bus.fwd_hit1), 64'd1);
    chk("fwd_data1", 64'(bus.fwd_data1), 64'd2);
    chk("fwd_hit2_x0", 64'(bus.fwd_hit2), 64'd0);
    repeat (3) step();
`endif
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
